// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and helpers for the divide-by-N ratio controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

    localparam int DIV_MIN_DEFAULT = 2;

    // Number of high cycles in a period of length n (rounds up for odd n).
    function automatic logic [31:0] half_hi(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_phase_gen.sv
// ============================================================================
// Module   : div_phase_gen
// Purpose  : Phase counter with wrap detect, registered div_out/tick decode and
//            a load port for the active ratio N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_phase_gen
    import div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_adv,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_n,
    output logic             o_wrap,
    output logic             o_div_out,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_n
);

    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_n;
    logic             r_div_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_k_inc;
    logic [31:0]      w_half;
    logic             w_hi_next;

    assign w_k_inc   = r_k + CNT_W'(1);
    assign w_half    = half_hi(32'(r_n));
    assign w_hi_next = (32'(w_k_inc) < w_half);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_div_out <= 1'b0;
            r_tick    <= 1'b0;
            r_n       <= CNT_W'(DEFAULT_DIV);
        end else begin
            if (i_start) begin
                // k=0 of a period is always in the high half
                r_k       <= '0;
                r_div_out <= 1'b1;
                r_tick    <= 1'b1;
            end else if (i_adv) begin
                r_k       <= w_k_inc;
                r_div_out <= w_hi_next;
                r_tick    <= 1'b0;
            end else begin
                r_k       <= '0;
                r_div_out <= 1'b0;
                r_tick    <= 1'b0;
            end
            if (i_load) begin
                r_n <= i_load_n;
            end
        end
    end

    assign o_wrap    = (r_k == (r_n - CNT_W'(1)));
    assign o_div_out = r_div_out;
    assign o_tick    = r_tick;
    assign o_n       = r_n;

endmodule

`default_nettype wire

// File: rtl/div_ratio_ctrl.sv
// ============================================================================
// Module   : div_ratio_ctrl
// Purpose  : Run/stop FSM, pending-ratio register and config handshake around
//            the divide-by-N phase generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ratio_ctrl
    import div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6,
    parameter int MIN_DIV     = DIV_MIN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic             r_pend_valid;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_cfg_err;

    logic             w_xfer;
    logic             w_legal;
    logic             w_wrap;
    logic             w_start;
    logic             w_adv;
    logic             w_load;
    logic [CNT_W-1:0] w_load_n;
    logic             w_pend_set;
    logic             w_pend_clr;

    assign w_xfer  = cfg_valid && !r_pend_valid;
    assign w_legal = (32'(cfg_div) >= 32'(MIN_DIV));

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_adv       = 1'b0;
        w_load      = 1'b0;
        w_load_n    = r_pend_div;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                // A pending value left by a transfer on the final wrap edge is applied here
                if (w_xfer && w_legal) begin
                    w_load   = 1'b1;
                    w_load_n = cfg_div;
                end else if (r_pend_valid) begin
                    w_load     = 1'b1;
                    w_pend_clr = 1'b1;
                end
                if (run) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                end
            end
            RUN: begin
                w_pend_set = w_xfer && w_legal;
                if (w_wrap) begin
                    if (r_pend_valid) begin
                        w_load     = 1'b1;
                        w_pend_clr = 1'b1;
                    end
                    if (run) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_adv = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pend_valid <= 1'b0;
            r_pend_div   <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_xfer && !w_legal;
            if (w_pend_set) begin
                r_pend_valid <= 1'b1;
                r_pend_div   <= cfg_div;
            end else if (w_pend_clr) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    div_phase_gen #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_adv     (w_adv),
        .i_load    (w_load),
        .i_load_n  (w_load_n),
        .o_wrap    (w_wrap),
        .o_div_out (div_out),
        .o_tick    (tick),
        .o_n       (cur_div)
    );

    assign cfg_ready = !r_pend_valid;
    assign cfg_err   = r_cfg_err;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_ratio_ctrl.sv
// ============================================================================
// Module   : tb_div_ratio_ctrl
// Purpose  : Randomized bench for div_ratio_ctrl against a period-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ratio_ctrl;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 6;
    localparam int MIN_DIV     = 2;
    localparam int N_CYCLES    = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_out;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] cur_div;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: each queued entry is one expected output cycle {tick, div_out}
    logic [1:0] m_q[$];
    bit         m_active;
    int         m_cur;
    int         m_pend;
    bit         m_err;

    always #5 clk = ~clk;

    div_ratio_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .MIN_DIV     (MIN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_period(input int n);
        for (int i = 0; i < n; i++) begin
            m_q.push_back({(i == 0) ? 1'b1 : 1'b0, (i < (n + 1) / 2) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_cur    = DEFAULT_DIV;
        m_pend   = -1;
        m_err    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit xfer;
        bit legal;
        bit was_active;
        xfer       = cfg_valid && (m_pend < 0);
        legal      = (int'(cfg_div) >= MIN_DIV);
        was_active = m_active;
        m_err      = xfer && !legal;
        if (was_active) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                if (m_pend >= 0) begin
                    m_cur  = m_pend;
                    m_pend = -1;
                end
                if (run) push_period(m_cur);
                else     m_active = 1'b0;
            end
            if (xfer && legal) m_pend = int'(cfg_div);
        end else begin
            if (xfer && legal) begin
                m_cur = int'(cfg_div);
            end else if (m_pend >= 0) begin
                m_cur  = m_pend;
                m_pend = -1;
            end
            if (run) begin
                m_active = 1'b1;
                push_period(m_cur);
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0] e;
        e = m_active ? m_q[0] : 2'b00;
        check("div_out",   32'(div_out),   32'(e[0]));
        check("tick",      32'(tick),      32'(e[1]));
        check("busy",      32'(busy),      32'(m_active));
        check("cur_div",   32'(cur_div),   32'(m_cur));
        check("cfg_ready", 32'(cfg_ready), 32'(m_pend < 0));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        for (int c = 0; c < N_CYCLES; c++) begin
            // Mostly stable run level with occasional toggles
            if ($urandom_range(0, 39) == 0) run = ~run;
            if (c < 20) run = 1'b1;
            cfg_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 99)) inside
                [0:69]:  cfg_div = CNT_W'($urandom_range(2, 9));
                [70:89]: cfg_div = CNT_W'($urandom_range(0, 1));
                [90:98]: cfg_div = CNT_W'($urandom_range(10, 40));
                default: cfg_div = 8'd255;
            endcase
            rst = (c > 50) && ($urandom_range(0, 699) == 0);
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
            #1;
            check_outputs();
        end

        rst       = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
